// File: rtl/run_det_pkg.sv
// Shared state-index helpers for the run-length detector and its one-hot twin.
package run_det_pkg;

   localparam int unsigned IDLE_IDX = 0;

   // Number of states: IDLE plus RUN_LEN zero-run and RUN_LEN one-run states.
   function automatic int unsigned ns(input int unsigned run_len);
      return 2 * run_len + 1;
   endfunction

   // Width of the binary state encoding.
   function automatic int unsigned sw(input int unsigned run_len);
      return $clog2(2 * run_len + 1);
   endfunction

   function automatic int unsigned zero_idx(input int unsigned k);
      return k;
   endfunction

   function automatic int unsigned one_idx(input int unsigned k, input int unsigned run_len);
      return run_len + k;
   endfunction

   function automatic logic is_terminal(input int unsigned idx, input int unsigned run_len);
      return (idx == run_len) || (idx == 2 * run_len);
   endfunction

endpackage

// File: rtl/run_onehot_fsm.sv
// One-hot run-length FSM, built from per-bit next-state equations so it never
// decodes the binary state it is cross-checked against.
module run_onehot_fsm
   import run_det_pkg::*;
#(
   parameter int unsigned RUN_LEN = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        w,
   input  logic                        restart_mode,
   output logic [ns(RUN_LEN)-1:0]      state_onehot
);

   localparam int unsigned NS = ns(RUN_LEN);

   logic [NS-1:0] state_q, state_d;

   // Per-bit next state; only the run chain selected by w can become active.
   always_comb begin
      int unsigned base;
      logic        mid;
      logic        hold;
      state_d = '0;
      base    = w ? RUN_LEN : 0;
      mid     = 1'b0;
      for (int k = 1; k < int'(RUN_LEN); k++) begin
         mid = mid | state_q[base + k];
      end
      // Terminal state of the selected chain stays put in overlap mode.
      hold = state_q[base + RUN_LEN] & ~restart_mode;
      for (int k = 1; k <= int'(RUN_LEN); k++) begin
         if (k == 1 && RUN_LEN == 1) begin
            state_d[base + k] = 1'b1;
         end else if (k == 1) begin
            state_d[base + k] = ~mid & ~hold;
         end else if (k == int'(RUN_LEN)) begin
            state_d[base + k] = state_q[base + k - 1] | hold;
         end else begin
            state_d[base + k] = state_q[base + k - 1];
         end
      end
      if (!en) begin
         state_d = state_q;
      end
   end

   // State register, reset to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= NS'(1) << IDLE_IDX;
      end else begin
         state_q <= state_d;
      end
   end

   assign state_onehot = state_q;

endmodule

// File: rtl/run_detector.sv
// Run-length detector: binary FSM plus independent one-hot FSM, a saturating
// detection counter and a sticky encoding-mismatch flag.
module run_detector
   import run_det_pkg::*;
#(
   parameter int unsigned RUN_LEN = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   input  logic                        w,
   input  logic                        restart_mode,
   output logic                        z,
   output logic [sw(RUN_LEN)-1:0]      state_bin,
   output logic [ns(RUN_LEN)-1:0]      state_onehot,
   output logic [CNT_W-1:0]            match_cnt,
   output logic                        enc_err
);

   localparam int unsigned NS = ns(RUN_LEN);
   localparam int unsigned SW = sw(RUN_LEN);

   logic [SW-1:0]    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             enc_err_q, enc_err_d;
   logic [NS-1:0]    onehot_state;
   logic [NS-1:0]    onehot_exp;

   // Binary next state: advance along the run chain selected by w, else restart it.
   always_comb begin
      int unsigned cur;
      int unsigned nxt;
      int unsigned base;
      cur  = int'(state_q);
      base = w ? RUN_LEN : 0;
      if (cur > base && cur < base + RUN_LEN) begin
         nxt = cur + 1;
      end else if (cur == base + RUN_LEN && !restart_mode) begin
         nxt = cur;
      end else begin
         nxt = base + 1;
      end
      state_d = en ? SW'(nxt) : state_q;
   end

   // Counter and mismatch checker next state.
   always_comb begin
      cnt_d = cnt_q;
      if (en && is_terminal(int'(state_d), RUN_LEN) && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end
      for (int i = 0; i < int'(NS); i++) begin
         onehot_exp[i] = (state_q == SW'(i));
      end
      enc_err_d = enc_err_q;
      if (onehot_state != onehot_exp || onehot_state == '0
          || (onehot_state & (onehot_state - 1'b1)) != '0) begin
         enc_err_d = 1'b1;
      end
   end

   // All registered state; reset wins over enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SW'(IDLE_IDX);
         cnt_q     <= '0;
         enc_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         enc_err_q <= enc_err_d;
      end
   end

   run_onehot_fsm #(
      .RUN_LEN (RUN_LEN)
   ) u_onehot (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .w            (w),
      .restart_mode (restart_mode),
      .state_onehot (onehot_state)
   );

   // Moore detect flag decoded from the registered binary state.
   always_comb begin
      z = is_terminal(int'(state_q), RUN_LEN);
   end

   assign state_bin    = state_q;
   assign state_onehot = onehot_state;
   assign match_cnt    = cnt_q;
   assign enc_err      = enc_err_q;

endmodule

// File: tb/tb_run_detector.sv
// Directed self-checking bench for run_detector with RUN_LEN=3, CNT_W=4.
module tb_run_detector;

   localparam int unsigned RL = 3;
   localparam int unsigned CW = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       w = 1'b0;
   logic       restart_mode = 1'b0;
   logic       z;
   logic [2:0] state_bin;
   logic [6:0] state_onehot;
   logic [3:0] match_cnt;
   logic       enc_err;

   int checks = 0;
   int errors = 0;

   run_detector #(
      .RUN_LEN (RL),
      .CNT_W   (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .w            (w),
      .restart_mode (restart_mode),
      .z            (z),
      .state_bin    (state_bin),
      .state_onehot (state_onehot),
      .match_cnt    (match_cnt),
      .enc_err      (enc_err)
   );

   always #5 clk = ~clk;

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic wi, input logic eni, input logic rsti);
      @(negedge clk);
      w     = wi;
      en    = eni;
      reset = rsti;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 1'b1);
      reset = 1'b0;
   endtask

   task automatic check_state(input string name, input logic [2:0] exp_s, input logic exp_z);
      logic [6:0] exp_oh;
      exp_oh = 7'b1 << exp_s;
      checks++;
      if (state_bin !== exp_s) begin
         errors++;
         $display("FAIL %s state_bin: got %0d expected %0d", name, state_bin, exp_s);
      end
      checks++;
      if (state_onehot !== exp_oh) begin
         errors++;
         $display("FAIL %s state_onehot: got %b expected %b", name, state_onehot, exp_oh);
      end
      checks++;
      if (z !== exp_z) begin
         errors++;
         $display("FAIL %s z: got %b expected %b", name, z, exp_z);
      end
   endtask

   task automatic check_cnt(input string name, input logic [3:0] exp_c);
      checks++;
      if (match_cnt !== exp_c) begin
         errors++;
         $display("FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, exp_c);
      end
   endtask

   task automatic check_err(input string name, input logic exp_e);
      checks++;
      if (enc_err !== exp_e) begin
         errors++;
         $display("FAIL %s enc_err: got %b expected %b", name, enc_err, exp_e);
      end
   endtask

   task automatic test_reset();
      step(1'($urandom), 1'($urandom), 1'b1);
      step(1'($urandom), 1'($urandom), 1'b1);
      reset = 1'b0;
      check_state("reset", 3'd0, 1'b0);
      check_cnt("reset", 4'd0);
      check_err("reset", 1'b0);
   endtask

   task automatic test_overlap();
      logic [2:0] exp_s [5] = '{3'd4, 3'd5, 3'd6, 3'd6, 3'd6};
      logic       exp_z [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      restart_mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b1, 1'b0);
         check_state("overlap", exp_s[i], exp_z[i]);
      end
      check_cnt("overlap", 4'd3);
   endtask

   task automatic test_restart();
      logic [2:0] exp_s [7] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1};
      logic       exp_z [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      restart_mode = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1, 1'b0);
         check_state("restart", exp_s[i], exp_z[i]);
      end
      check_cnt("restart", 4'd2);
   endtask

   task automatic test_alternating();
      logic [2:0] exp_s [6] = '{3'd1, 3'd4, 3'd1, 3'd4, 3'd1, 3'd4};
      do_reset();
      restart_mode = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1'(i % 2), 1'b1, 1'b0);
         check_state("alternating", exp_s[i], 1'b0);
      end
      check_cnt("alternating", 4'd0);
   endtask

   task automatic test_enable_hold();
      do_reset();
      restart_mode = 1'b0;
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check_state("hold_pre", 3'd5, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check_state("hold", 3'd5, 1'b0);
      end
      step(1'b1, 1'b1, 1'b0);
      check_state("hold_resume", 3'd6, 1'b1);
      check_cnt("hold_resume", 4'd1);
      // Count freezes while z stays high with en low.
      step(1'b1, 1'b0, 1'b0);
      check_state("hold_term", 3'd6, 1'b1);
      check_cnt("hold_term", 4'd1);
      step(1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      check_state("reset_mid", 3'd0, 1'b0);
      check_cnt("reset_mid", 4'd0);
   endtask

   task automatic test_saturation_mismatch();
      logic [3:0] exp_c;
      logic [2:0] exp_s;
      do_reset();
      restart_mode = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step(1'b0, 1'b1, 1'b0);
         exp_c = (i < 3) ? 4'd0 : ((i - 2 > 15) ? 4'd15 : 4'(i - 2));
         exp_s = (i < 3) ? 3'(i) : 3'd3;
         check_state("sat", exp_s, i >= 3);
         check_cnt("sat", exp_c);
         check_err("sat", 1'b0);
      end
      @(negedge clk);
      en = 1'b0;
      force dut.onehot_state = 7'b0000100;
      @(posedge clk);
      #1;
      check_err("mismatch", 1'b1);
      @(negedge clk);
      release dut.onehot_state;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0);
         check_err("mismatch_sticky", 1'b1);
      end
      do_reset();
      check_err("mismatch_clear", 1'b0);
      check_state("mismatch_clear", 3'd0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_restart();
      test_alternating();
      test_enable_hold();
      test_saturation_mismatch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
